bus_iface: RTL and testbench
============================

// Module: bus_iface
// PURPOSE
//  8085 multiplexed bus interface unit, downstream of the T-state control block.
//  Consumes the control block's current T-state and cycle status.
//  Drives A15-A8 and the multiplexed AD7-AD0 bus.
//  Latches the address and write data per machine cycle.
//  Captures read data at the end of T3, and signals the instruction register for opcode fetches.
//  Counts wait states and flags a stalled bus.
// PARAMETERS
//  DATASIZE   8    data bus width
//  ADDRSIZE   16   address width (upper byte = ADDRSIZE-DATASIZE bits)
//  WAIT_MAX   15   TW count at which wait_tmo asserts (4-bit counter, saturating)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, synchronous, active-high
//  tstate     in   4   current T-state: TR=0,T1=1,T2=2,T3=3,T4=4,T5=5,T6=6,TH=7,TW=8,TT=9
//  stat       in   3   cycle status {io/m_,s1,s0}: OF=011,MW=001,MR=010,DW=101,DR=110,INTA=111
//  addr       in   16  cycle address, valid while tstate==T1
//  wdata      in   8   write data, valid while tstate==T1 for write cycles
//  ad_in      in   8   AD7-0 pad input
//  a_hi       out  8   A15-8 pad output
//  a_hi_oe    out  1   A15-8 output enable
//  ad_out     out  8   AD7-0 pad output
//  ad_oe      out  1   AD7-0 output enable
//  ale        out  1   address latch enable
//  rdata      out  8   captured read data
//  rdata_vld  out  1   one-cycle strobe: rdata updated
//  ir_load    out  1   one-cycle strobe: rdata is an opcode (OF cycle)
//  wait_cnt   out  4   TW cycles in the current machine cycle
//  wait_tmo   out  1   wait_cnt reached WAIT_MAX
// BEHAVIOUR
//  - Reset values: all registers 0. Outputs: a_hi_oe=0, ad_oe=0, ale=0, rdata=0, rdata_vld=0, ir_load=0,
//    wait_cnt=0, wait_tmo=0.
//  - Registers:
//    - addr_q, wdata_q, stat_q load on every clock edge where tstate==T1.
//    - Outside T1 they hold their value.
//  - Outputs are combinational from tstate and the registers; no registered latency.
//  - T1:
//    - ale=1, ad_oe=1, a_hi_oe=1.
//    - ad_out=addr[7:0], driven from the port because addr_q is not loaded yet.
//    - a_hi=addr[15:8]; for DW/DR, a_hi=addr[7:0] (port address mirrored).
//  - T2, TW, T3:
//    - ale=0, a_hi_oe=1.
//    - a_hi=addr_q[15:8], or addr_q[7:0] for IO cycles.
//    - Write (stat_q MW/DW): ad_oe=1, ad_out=wdata_q.
//    - Read (OF/MR/DR/INTA): ad_oe=0.
//  - T4-T6: a_hi_oe=1, holding addr_q; ad_oe=0, ale=0.
//  - TR/TH/TT: a_hi_oe=0, ad_oe=0, ale=0 (bus floated).
//  - Read capture:
//    - At the clock edge ending T3 of a read cycle: rdata<=ad_in, then rdata_vld=1 for exactly the next cycle.
//    - ir_load=1 in that same cycle only if stat_q==OF.
//    - Write cycles never touch rdata.
//  - Wait counter:
//    - Cleared on every edge where tstate==T1.
//    - Increments on each edge where tstate==TW; saturates at 15.
//    - wait_tmo=(wait_cnt>=WAIT_MAX), held until the next T1.
//  - tstate jumping from T2/TW to TH or TR mid-cycle: no capture, strobes stay 0, and the bus floats immediately.
//  - rst asserted mid-cycle: all registers clear on that edge, any pending strobe is suppressed, and the bus floats.
//  - Illegal tstate codes (10-15): treated as TR.
// TESTING
//  - Reset: rst=1 for 2 clk -> ad_oe=0, a_hi_oe=0, ale=0, rdata=00, wait_cnt=0.
//  - Opcode fetch, addr=1234, ad_in=3E at T3, sequence T1,T2,T3,T4:
//    - T1: ale=1, ad_out=34, a_hi=12.
//    - T2: ad_oe=0.
//    - T4: rdata=3E, rdata_vld=1, ir_load=1.
//  - Memory write MW, addr=8001, wdata=A5:
//    - T1: ad_out=01.
//    - T2/T3: ad_out=A5, ad_oe=1.
//    - rdata unchanged, rdata_vld=0.
//  - IO read DR, addr=0042, ad_in=7F:
//    - T1: a_hi=42, ad_out=42.
//    - After T3: rdata=7F, rdata_vld=1, ir_load=0.
//  - Wait states: T1,T2,TW x3,T3 -> wait_cnt=3, wait_tmo=0; TW x16 -> wait_cnt=15, wait_tmo=1; next T1 clears both.
//  - Abort and reset: tstate T2->TH -> bus floated, no rdata_vld; rst during T3 of MR -> rdata stays 00, no strobe.

Source files
------------

// File: rtl/bus_iface.sv
// 8085 multiplexed bus interface unit.
// Takes the T-state and cycle status from the control block and drives the
// A15-A8 / AD7-AD0 pads, captures read data at the end of T3, strobes the
// instruction register on opcode fetches, and counts wait states.
module bus_iface #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned ADDRSIZE = 16,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   tstate,
  input  logic [2:0]                   stat,
  input  logic [ADDRSIZE-1:0]          addr,
  input  logic [DATASIZE-1:0]          wdata,
  input  logic [DATASIZE-1:0]          ad_in,
  output logic [ADDRSIZE-DATASIZE-1:0] a_hi,
  output logic                         a_hi_oe,
  output logic [DATASIZE-1:0]          ad_out,
  output logic                         ad_oe,
  output logic                         ale,
  output logic [DATASIZE-1:0]          rdata,
  output logic                         rdata_vld,
  output logic                         ir_load,
  output logic [3:0]                   wait_cnt,
  output logic                         wait_tmo
);

  localparam int unsigned HiW = ADDRSIZE - DATASIZE;

  // T-state codes; 10-15 are not decoded and fall through as TR
  localparam logic [3:0] TsTr = 4'd0;
  localparam logic [3:0] TsT1 = 4'd1;
  localparam logic [3:0] TsT2 = 4'd2;
  localparam logic [3:0] TsT3 = 4'd3;
  localparam logic [3:0] TsT4 = 4'd4;
  localparam logic [3:0] TsT5 = 4'd5;
  localparam logic [3:0] TsT6 = 4'd6;
  localparam logic [3:0] TsTh = 4'd7;
  localparam logic [3:0] TsTw = 4'd8;
  localparam logic [3:0] TsTt = 4'd9;

  // Cycle status codes {io/m_, s1, s0}
  localparam logic [2:0] StOf   = 3'b011;
  localparam logic [2:0] StMw   = 3'b001;
  localparam logic [2:0] StMr   = 3'b010;
  localparam logic [2:0] StDw   = 3'b101;
  localparam logic [2:0] StDr   = 3'b110;
  localparam logic [2:0] StInta = 3'b111;

  localparam logic [3:0] WaitMax = 4'(WAIT_MAX);

  logic [ADDRSIZE-1:0] addr_q;
  logic [DATASIZE-1:0] wdata_q;
  logic [2:0]          stat_q;
  logic [DATASIZE-1:0] rdata_q;
  logic                rdata_vld_q;
  logic                ir_load_q;
  logic [3:0]          wait_cnt_q;

  logic ph_t1, ph_data, ph_hold;
  logic is_read_q, is_write_q, is_io_q, is_io_in;

  // Classify the current T-state into bus phases
  always_comb begin
    ph_t1   = 1'b0;
    ph_data = 1'b0;
    ph_hold = 1'b0;
    case (tstate)
      TsT1:             ph_t1   = 1'b1;
      TsT2, TsTw, TsT3: ph_data = 1'b1;
      TsT4, TsT5, TsT6: ph_hold = 1'b1;
      TsTr, TsTh, TsTt: ;
      default:          ;
    endcase
  end

  // Decode the latched cycle type; only DW/DR mirror the port address on A15-8
  always_comb begin
    is_read_q  = (stat_q == StOf) || (stat_q == StMr) || (stat_q == StDr) || (stat_q == StInta);
    is_write_q = (stat_q == StMw) || (stat_q == StDw);
    is_io_q    = (stat_q == StDw) || (stat_q == StDr);
    is_io_in   = (stat == StDw) || (stat == StDr);
  end

  // Per-cycle latches, read capture, strobes and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      stat_q      <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      ir_load_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      if (tstate == TsT1) begin
        addr_q  <= addr;
        wdata_q <= wdata;
        stat_q  <= stat;
      end
      if ((tstate == TsT3) && is_read_q) begin
        rdata_q <= ad_in;
      end
      rdata_vld_q <= (tstate == TsT3) && is_read_q;
      ir_load_q   <= (tstate == TsT3) && (stat_q == StOf);
      if (tstate == TsT1) begin
        wait_cnt_q <= '0;
      end else if ((tstate == TsTw) && (wait_cnt_q != 4'hf)) begin
        wait_cnt_q <= wait_cnt_q + 4'd1;
      end
    end
  end

  // Pad drive; reset floats the bus immediately, not only after the edge
  always_comb begin
    a_hi    = '0;
    a_hi_oe = 1'b0;
    ad_out  = '0;
    ad_oe   = 1'b0;
    ale     = 1'b0;
    if (!rst) begin
      if (ph_t1) begin
        // addr_q is not loaded until the end of T1, so drive from the port
        ale     = 1'b1;
        ad_oe   = 1'b1;
        a_hi_oe = 1'b1;
        ad_out  = addr[DATASIZE-1:0];
        a_hi    = is_io_in ? HiW'(addr[DATASIZE-1:0]) : addr[ADDRSIZE-1:DATASIZE];
      end else if (ph_data || ph_hold) begin
        a_hi_oe = 1'b1;
        a_hi    = is_io_q ? HiW'(addr_q[DATASIZE-1:0]) : addr_q[ADDRSIZE-1:DATASIZE];
        if (ph_data && is_write_q) begin
          ad_oe  = 1'b1;
          ad_out = wdata_q;
        end
      end
    end
  end

  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign ir_load   = ir_load_q;
  assign wait_cnt  = wait_cnt_q;
  assign wait_tmo  = (wait_cnt_q >= WaitMax);

endmodule

// File: tb/tb_bus_iface.sv
// Self-checking bench for bus_iface: directed scenarios with literal
// expectations plus randomized machine cycles against a behavioural model.
module tb_bus_iface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  tstate = 4'd0;
  logic [2:0]  stat = 3'd0;
  logic [15:0] addr = 16'd0;
  logic [7:0]  wdata = 8'd0;
  logic [7:0]  ad_in = 8'd0;
  logic [7:0]  a_hi, ad_out, rdata;
  logic        a_hi_oe, ad_oe, ale, rdata_vld, ir_load, wait_tmo;
  logic [3:0]  wait_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  bus_iface #(.DATASIZE(8), .ADDRSIZE(16), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .tstate(tstate), .stat(stat), .addr(addr), .wdata(wdata),
    .ad_in(ad_in), .a_hi(a_hi), .a_hi_oe(a_hi_oe), .ad_out(ad_out), .ad_oe(ad_oe),
    .ale(ale), .rdata(rdata), .rdata_vld(rdata_vld), .ir_load(ir_load),
    .wait_cnt(wait_cnt), .wait_tmo(wait_tmo)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] OF = 3'b011, MW = 3'b001, MR = 3'b010;
  localparam logic [2:0] DW = 3'b101, DR = 3'b110, INTA = 3'b111;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the current machine cycle looks like to the pads
  logic [15:0] m_addr = 16'd0;
  logic [7:0]  m_wdata = 8'd0;
  logic [2:0]  m_stat = 3'd0;
  logic [7:0]  m_rdata = 8'd0;
  bit          m_vld = 1'b0;
  bit          m_ir = 1'b0;
  int          m_waits = 0;

  function automatic bit kind_read(input logic [2:0] s);
    return s inside {OF, MR, DR, INTA};
  endfunction
  function automatic bit kind_write(input logic [2:0] s);
    return s inside {MW, DW};
  endfunction
  function automatic bit kind_io(input logic [2:0] s);
    return s inside {DW, DR};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_addr <= 0; m_wdata <= 0; m_stat <= 0; m_rdata <= 0;
      m_vld <= 0; m_ir <= 0; m_waits <= 0;
    end else begin
      m_vld <= (tstate == 3) && kind_read(m_stat);
      m_ir  <= (tstate == 3) && (m_stat == OF);
      if (tstate == 3 && kind_read(m_stat)) m_rdata <= ad_in;
      if (tstate == 1) begin
        m_addr <= addr; m_wdata <= wdata; m_stat <= stat; m_waits <= 0;
      end else if (tstate == 8) begin
        m_waits <= (m_waits + 1 > 15) ? 15 : m_waits + 1;
      end
    end
  end

  // Compare process: every negedge once the DUT has been reset
  always @(negedge clk) begin
    if (cmp_en) begin
      bit e_ale, e_adoe, e_hioe;
      logic [7:0] e_ad, e_hi;
      int ts;
      ts = (tstate > 9) ? 0 : int'(tstate);
      e_ale = 0; e_adoe = 0; e_hioe = 0; e_ad = 0; e_hi = 0;
      if (!rst) begin
        if (ts == 1) begin
          e_ale = 1; e_adoe = 1; e_hioe = 1; e_ad = addr[7:0];
          e_hi = kind_io(stat) ? addr[7:0] : addr[15:8];
        end else if (ts inside {2, 3, 4, 5, 6, 8}) begin
          e_hioe = 1;
          e_hi = kind_io(m_stat) ? m_addr[7:0] : m_addr[15:8];
          if (ts inside {2, 3, 8} && kind_write(m_stat)) begin
            e_adoe = 1; e_ad = m_wdata;
          end
        end
      end
      chk("ale", 16'(ale), 16'(e_ale));
      chk("ad_oe", 16'(ad_oe), 16'(e_adoe));
      chk("a_hi_oe", 16'(a_hi_oe), 16'(e_hioe));
      if (e_adoe) chk("ad_out", 16'(ad_out), 16'(e_ad));
      if (e_hioe) chk("a_hi", 16'(a_hi), 16'(e_hi));
      chk("rdata", 16'(rdata), 16'(m_rdata));
      chk("rdata_vld", 16'(rdata_vld), 16'(m_vld));
      chk("ir_load", 16'(ir_load), 16'(m_ir));
      chk("wait_cnt", 16'(wait_cnt), 16'(m_waits));
      chk("wait_tmo", 16'(wait_tmo), 16'(m_waits >= 15));
    end
  end

  // Apply inputs just after an edge, return just after the following negedge
  task automatic step(input logic r, input logic [3:0] ts, input logic [2:0] st,
                      input logic [15:0] a, input logic [7:0] wd, input logic [7:0] ai);
    @(posedge clk);
    #1;
    rst = r; tstate = ts; stat = st; addr = a; wdata = wd; ad_in = ai;
    #5;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 3'd0, 16'd0, 8'd0, 8'd0);
  endtask

  initial begin
    int nw;
    logic [2:0] st;
    logic [2:0] kinds [6];
    logic [15:0] a;
    logic [7:0] wd;
    kinds[0] = OF; kinds[1] = MW; kinds[2] = MR; kinds[3] = DW; kinds[4] = DR; kinds[5] = INTA;

    // Reset
    step(1'b1, 4'd0, 3'd0, 16'd0, 8'd0, 8'd0);
    step(1'b1, 4'd0, 3'd0, 16'd0, 8'd0, 8'd0);
    cmp_en = 1'b1;
    step(1'b0, 4'd0, 3'd0, 16'd0, 8'd0, 8'd0);
    chk("rst_ad_oe", 16'(ad_oe), 16'h0);
    chk("rst_a_hi_oe", 16'(a_hi_oe), 16'h0);
    chk("rst_ale", 16'(ale), 16'h0);
    chk("rst_rdata", 16'(rdata), 16'h00);
    chk("rst_wait_cnt", 16'(wait_cnt), 16'h0);

    // Opcode fetch 1234 -> 3E
    step(1'b0, 4'd1, OF, 16'h1234, 8'h00, 8'h00);
    chk("of_t1_ale", 16'(ale), 16'h1);
    chk("of_t1_ad_out", 16'(ad_out), 16'h34);
    chk("of_t1_a_hi", 16'(a_hi), 16'h12);
    step(1'b0, 4'd2, OF, 16'h0, 8'h00, 8'h00);
    chk("of_t2_ad_oe", 16'(ad_oe), 16'h0);
    step(1'b0, 4'd3, OF, 16'h0, 8'h00, 8'h3E);
    step(1'b0, 4'd4, OF, 16'h0, 8'h00, 8'h00);
    chk("of_t4_rdata", 16'(rdata), 16'h3E);
    chk("of_t4_vld", 16'(rdata_vld), 16'h1);
    chk("of_t4_ir", 16'(ir_load), 16'h1);

    // Memory write 8001 <- A5
    step(1'b0, 4'd1, MW, 16'h8001, 8'hA5, 8'h00);
    chk("mw_t1_ad_out", 16'(ad_out), 16'h01);
    step(1'b0, 4'd2, MW, 16'h0, 8'h00, 8'h55);
    chk("mw_t2_ad_out", 16'(ad_out), 16'hA5);
    chk("mw_t2_ad_oe", 16'(ad_oe), 16'h1);
    step(1'b0, 4'd3, MW, 16'h0, 8'h00, 8'h55);
    chk("mw_t3_ad_out", 16'(ad_out), 16'hA5);
    step(1'b0, 4'd0, 3'd0, 16'h0, 8'h00, 8'h00);
    chk("mw_rdata", 16'(rdata), 16'h3E);
    chk("mw_vld", 16'(rdata_vld), 16'h0);

    // IO read 42 -> 7F
    step(1'b0, 4'd1, DR, 16'h0042, 8'h00, 8'h00);
    chk("dr_t1_a_hi", 16'(a_hi), 16'h42);
    chk("dr_t1_ad_out", 16'(ad_out), 16'h42);
    step(1'b0, 4'd2, DR, 16'h0, 8'h00, 8'h00);
    chk("dr_t2_a_hi", 16'(a_hi), 16'h42);
    step(1'b0, 4'd3, DR, 16'h0, 8'h00, 8'h7F);
    step(1'b0, 4'd0, 3'd0, 16'h0, 8'h00, 8'h00);
    chk("dr_rdata", 16'(rdata), 16'h7F);
    chk("dr_vld", 16'(rdata_vld), 16'h1);
    chk("dr_ir", 16'(ir_load), 16'h0);

    // Wait states: 3, then 16 (saturating), then cleared by T1
    step(1'b0, 4'd1, MR, 16'h2000, 8'h00, 8'h00);
    step(1'b0, 4'd2, MR, 16'h0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd8, MR, 16'h0, 8'h00, 8'h00);
    step(1'b0, 4'd3, MR, 16'h0, 8'h00, 8'h11);
    chk("w3_cnt", 16'(wait_cnt), 16'h3);
    chk("w3_tmo", 16'(wait_tmo), 16'h0);
    step(1'b0, 4'd1, MR, 16'h2001, 8'h00, 8'h00);
    step(1'b0, 4'd2, MR, 16'h0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 4'd8, MR, 16'h0, 8'h00, 8'h00);
    step(1'b0, 4'd3, MR, 16'h0, 8'h00, 8'h22);
    chk("w16_cnt", 16'(wait_cnt), 16'hF);
    chk("w16_tmo", 16'(wait_tmo), 16'h1);
    step(1'b0, 4'd1, MR, 16'h2002, 8'h00, 8'h00);
    step(1'b0, 4'd2, MR, 16'h0, 8'h00, 8'h00);
    chk("wclr_cnt", 16'(wait_cnt), 16'h0);
    chk("wclr_tmo", 16'(wait_tmo), 16'h0);

    // Abort T2 -> TH
    step(1'b0, 4'd7, MR, 16'h0, 8'h00, 8'h00);
    chk("abort_ad_oe", 16'(ad_oe), 16'h0);
    chk("abort_a_hi_oe", 16'(a_hi_oe), 16'h0);
    step(1'b0, 4'd0, 3'd0, 16'h0, 8'h00, 8'h00);
    chk("abort_vld", 16'(rdata_vld), 16'h0);

    // Reset during T3 of a memory read
    step(1'b1, 4'd0, 3'd0, 16'h0, 8'h00, 8'h00);
    step(1'b0, 4'd1, MR, 16'h4321, 8'h00, 8'h00);
    step(1'b0, 4'd2, MR, 16'h0, 8'h00, 8'h00);
    step(1'b1, 4'd3, MR, 16'h0, 8'h00, 8'h99);
    chk("rstmid_a_hi_oe", 16'(a_hi_oe), 16'h0);
    step(1'b0, 4'd0, 3'd0, 16'h0, 8'h00, 8'h00);
    chk("rstmid_rdata", 16'(rdata), 16'h00);
    chk("rstmid_vld", 16'(rdata_vld), 16'h0);

    // Randomized machine cycles
    for (int c = 0; c < 300; c++) begin
      st = kinds[$urandom_range(0, 5)];
      a  = 16'($urandom);
      wd = 8'($urandom);
      step(1'b0, 4'd1, st, a, wd, 8'($urandom));
      step(1'b0, 4'd2, 3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        step(1'b0, ($urandom_range(0, 1) == 0) ? 4'd7 : 4'd0, 3'd0, 16'd0, 8'd0, 8'd0);
        continue;
      end
      nw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 3));
      for (int i = 0; i < nw; i++)
        step(1'b0, 4'd8, 3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      step($urandom_range(0, 29) == 0, 4'd3, 3'($urandom), 16'($urandom), 8'($urandom),
           8'($urandom));
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        step(1'b0, 4'(4 + i), 3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 3) == 0)
        step(1'b0, 4'($urandom_range(9, 15)), 3'($urandom), 16'($urandom), 8'($urandom),
             8'($urandom));
    end

    // Fully random T-state stream
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 49) == 0, 4'($urandom), 3'($urandom), 16'($urandom),
           8'($urandom), 8'($urandom));

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
